// File: rtl/imem_port_arbiter.sv
// Arbitrates one single-port, 1-cycle-latency memory between instruction fetch
// and load/store; load/store has priority, a starvation counter guarantees fetch progress.
module imem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      RESP_IDLE,
      RESP_IF,
      RESP_LS
   } resp_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   resp_t      resp;
   resp_t      resp_next;
   logic       killed;
   logic [3:0] starve_cnt;
   logic       force_if;

   assign force_if = (starve_cnt == STARVE_LIM);
   assign if_gnt   = if_req & (~ls_req | force_if);
   assign ls_gnt   = ls_req & ~if_gnt;

   // NOTE: state is updated with non-blocking assignments so every register samples
   // pre-edge values; the async reset clears only control state, never the data path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp       <= RESP_IDLE;
         killed     <= 1'b0;
         starve_cnt <= 4'd0;
      end else begin
         resp   <= resp_next;
         killed <= if_gnt & if_flush;
         if (if_req & ~if_gnt) begin
            if (starve_cnt != STARVE_LIM)
               starve_cnt <= starve_cnt + 4'd1;
         end else begin
            starve_cnt <= 4'd0;
         end
      end
   end

   // NOTE: a default assignment first keeps this block free of inferred latches.
   always_comb begin
      resp_next = RESP_IDLE;
      if (if_gnt)
         resp_next = RESP_IF;
      else if (ls_gnt & ~ls_we)
         resp_next = RESP_LS;
   end

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (if_gnt) begin
         mem_addr = if_addr;
      end else if (ls_gnt) begin
         mem_addr  = ls_addr;
         mem_we    = ls_we & rst_n;
         mem_wdata = ls_wdata;
      end
      // A flush arriving while the fetch response is on the bus kills it in-cycle.
      if_rvalid = (resp == RESP_IF) & ~killed & ~if_flush;
      ls_rvalid = (resp == RESP_LS);
      if_rdata  = mem_rdata;
      ls_rdata  = mem_rdata;
   end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed self-checking bench for imem_port_arbiter with a 1-cycle-latency memory model.
module tb_imem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_flush, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        ls_req, ls_we, ls_gnt, ls_rvalid;
   logic [31:0] ls_addr, ls_wdata, ls_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;
   logic [31:0] mem [0:255];

   int checks = 0;
   int errors = 0;

   imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Word-addressed synchronous memory: read data appears the cycle after its address.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[9:2]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_if, prev_if;
      rst_n = 1'b0; if_req = 0; if_addr = 0; if_flush = 0;
      ls_req = 1; ls_we = 1; ls_addr = 32'h40; ls_wdata = 32'h1234_5678;
      #1;
      check("rst_if_rvalid", 32'(if_rvalid), 0);
      check("rst_ls_rvalid", 32'(ls_rvalid), 0);
      check("rst_ls_gnt", 32'(ls_gnt), 1);
      check("rst_mem_we_blocked", 32'(mem_we), 0);
      ls_req = 0;
      tick;
      #2 rst_n = 1'b1;

      // Store the instruction word used by the fetch tests.
      ls_req = 1; ls_we = 1; ls_addr = 32'h10; ls_wdata = 32'h0080_0093;
      #1;
      check("st0_ls_gnt", 32'(ls_gnt), 1);
      check("st0_mem_we", 32'(mem_we), 1);
      check("st0_mem_addr", mem_addr, 32'h10);
      check("st0_mem_wdata", mem_wdata, 32'h0080_0093);
      tick;
      ls_req = 0; ls_we = 0;
      #1;
      check("st0_no_rvalid", 32'(ls_rvalid), 0);
      check("idle_mem_we", 32'(mem_we), 0);
      check("idle_mem_addr", mem_addr, 0);

      // Single fetch.
      if_req = 1; if_addr = 32'h10;
      #1;
      check("f1_if_gnt", 32'(if_gnt), 1);
      check("f1_mem_addr", mem_addr, 32'h10);
      check("f1_mem_we", 32'(mem_we), 0);
      tick;
      if_req = 0;
      #1;
      check("f1_if_rvalid", 32'(if_rvalid), 1);
      check("f1_if_rdata", if_rdata, 32'h0080_0093);
      check("f1_ls_rvalid", 32'(ls_rvalid), 0);
      tick;
      check("f1_rvalid_drop", 32'(if_rvalid), 0);

      // Store then load.
      ls_req = 1; ls_we = 1; ls_addr = 32'h20; ls_wdata = 32'hDEAD_BEEF;
      #1;
      check("st_mem_we", 32'(mem_we), 1);
      check("st_mem_addr", mem_addr, 32'h20);
      tick;
      ls_we = 0;
      #1;
      check("st_no_rvalid", 32'(ls_rvalid), 0);
      check("ld_ls_gnt", 32'(ls_gnt), 1);
      check("ld_mem_we", 32'(mem_we), 0);
      tick;
      ls_req = 0;
      #1;
      check("ld_ls_rvalid", 32'(ls_rvalid), 1);
      check("ld_ls_rdata", ls_rdata, 32'hDEAD_BEEF);
      check("ld_if_rvalid", 32'(if_rvalid), 0);
      tick;

      // Contention: ls wins four ties, then fetch is forced once, repeating.
      if_req = 1; if_addr = 32'h10; ls_req = 1; ls_we = 0; ls_addr = 32'h20;
      prev_if = 1'b0;
      for (int k = 0; k < 10; k++) begin
         exp_if = ((k % 5) == 4);
         #1;
         check($sformatf("ct%0d_if_gnt", k), 32'(if_gnt), 32'(exp_if));
         check($sformatf("ct%0d_ls_gnt", k), 32'(ls_gnt), 32'(!exp_if));
         if (k > 0) begin
            check($sformatf("ct%0d_if_rvalid", k), 32'(if_rvalid), 32'(prev_if));
            check($sformatf("ct%0d_ls_rvalid", k), 32'(ls_rvalid), 32'(!prev_if));
            check($sformatf("ct%0d_rdata", k), prev_if ? if_rdata : ls_rdata,
                  prev_if ? 32'h0080_0093 : 32'hDEAD_BEEF);
         end
         prev_if = exp_if;
         tick;
      end
      if_req = 0; ls_req = 0;
      #1;
      check("ct_last_if_rvalid", 32'(if_rvalid), 1);
      check("ct_last_ls_rvalid", 32'(ls_rvalid), 0);
      tick;

      // Flush together with the grant.
      if_req = 1; if_flush = 1;
      #1;
      check("fl1_if_gnt", 32'(if_gnt), 1);
      tick;
      if_req = 0; if_flush = 0;
      #1;
      check("fl1_if_rvalid", 32'(if_rvalid), 0);
      tick;
      // Flush in the response cycle of a clean grant.
      if_req = 1;
      tick;
      if_req = 0; if_flush = 1;
      #1;
      check("fl2_if_rvalid", 32'(if_rvalid), 0);
      if_flush = 0;
      tick;
      // Next unflushed fetch is delivered normally.
      if_req = 1;
      tick;
      if_req = 0;
      #1;
      check("fl3_if_rvalid", 32'(if_rvalid), 1);
      check("fl3_if_rdata", if_rdata, 32'h0080_0093);
      tick;
      // Flush does not touch load responses.
      ls_req = 1; if_flush = 1;
      tick;
      ls_req = 0;
      #1;
      check("fl_ls_rvalid", 32'(ls_rvalid), 1);
      if_flush = 0;
      tick;

      // Reset mid-flight with a partly built-up starvation count.
      if_req = 1; ls_req = 1; ls_we = 0;
      tick;
      tick;
      tick;
      check("rm_ls_rvalid_pre", 32'(ls_rvalid), 1);
      rst_n = 1'b0;
      #1;
      check("rm_ls_rvalid_drop", 32'(ls_rvalid), 0);
      check("rm_mem_we", 32'(mem_we), 0);
      tick;
      #2 rst_n = 1'b1;
      #1;
      check("rm_post_if_rvalid", 32'(if_rvalid), 0);
      check("rm_post_ls_rvalid", 32'(ls_rvalid), 0);
      for (int k = 0; k < 5; k++) begin
         exp_if = (k == 4);
         check($sformatf("rm%0d_if_gnt", k), 32'(if_gnt), 32'(exp_if));
         check($sformatf("rm%0d_ls_gnt", k), 32'(ls_gnt), 32'(!exp_if));
         tick;
      end
      if_req = 0; ls_req = 0;
      tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
